// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32 I/B-type instruction encoder for the program
// loader. Packs register fields and a signed immediate into an instruction
// word, drops tuples whose immediate cannot be represented, and tags each
// emitted word with a sequential byte address.
//
// Handshake (both ports): a beat transfers on a rising edge where valid and
// ready are both high; a producer holds valid and its payload steady until
// that edge, and ready may depend combinationally on the downstream state.
module instr_encoder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  fmt,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [31:0]           imm,
   input  logic                  addr_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  err,
   output logic [7:0]            err_cnt
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

   // S1: accepted tuple, already encoded, plus its illegal-immediate flag
   logic        s1_valid;
   logic        s1_err;
   logic [31:0] s1_instr;

   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] xfer_addr;

   logic s2_free;
   logic s1_adv;
   logic s2_load;
   logic accept;

   logic [31:0] enc_i;
   logic [31:0] enc_b;
   logic        ok_i;
   logic        ok_b;
   logic        imm_bad;

   // Field packing; B-type drops imm[0], which must be zero to be legal
   assign enc_i = {imm[11:0], rs1, funct3, rd, opcode};
   assign enc_b = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};

   // An immediate fits when every bit above the top encoded bit copies the sign
   assign ok_i    = (&imm[31:11]) | ~(|imm[31:11]);
   assign ok_b    = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign imm_bad = fmt ? ~ok_b : ~ok_i;

   // Illegal tuples leave S1 unconditionally so they never stall the stream
   assign s2_free  = ~out_valid | out_ready;
   assign s1_adv   = s1_valid & (s1_err | s2_free);
   assign in_ready = rst_n & (~s1_valid | s1_adv);
   assign accept   = in_valid & in_ready;
   assign s2_load  = s1_adv & ~s1_err;

   // A clear coincident with a transfer addresses that word at the base
   assign xfer_addr = addr_clr ? BASE_ADDR : next_addr;

   // S1 register: refill whenever the slot is empty or being vacated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         s1_instr <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (accept) begin
            s1_err   <= imm_bad;
            s1_instr <= fmt ? enc_b : enc_i;
         end
      end
   end

   // S2 output register: payload only changes on a load, keeping it stable under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE_ADDR;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_instr <= s1_instr;
         out_addr  <= xfer_addr;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Address counter: advances only for legal words entering S2, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_addr <= BASE_ADDR;
      end else if (s2_load) begin
         next_addr <= xfer_addr + ADDR_STEP;
      end else if (addr_clr) begin
         next_addr <= BASE_ADDR;
      end
   end

   // Error pulse and saturating drop counter, registered after the discard edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         err <= s1_adv & s1_err;
         if (s1_adv && s1_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a
// behavioural model (range rules, arithmetic field packing, an independent
// immediate decoder and a word-order queue). Two instances share stimulus:
// one with default parameters, one with a 4-bit address starting at 8.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        addr_clr;
  logic        out_ready;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_cnt;
  logic        in_ready_b, out_valid_b, err_b;
  logic [31:0] out_instr_b;
  logic [3:0]  out_addr_b;
  logic [7:0]  err_cnt_b;

  // clock / reset block
  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(4'd8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .addr_clr(addr_clr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_addr(out_addr_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: {fmt, imm, expected word} in emission order
  logic [64:0] exp_q[$];
  int unsigned idx = 0;
  int          ill_cnt = 0;
  int          err_seen = 0;
  int          ov_seen = 0;
  logic        hold = 1'b0;
  logic [31:0] hold_instr, hold_addr;
  logic [31:0] last_instr, last_addr;
  logic [3:0]  last_addr_b;
  logic        accepted;
  int          bnd[11] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, 0, 1};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(bit f, int v);
    if (!f) return (v >= -2048) && (v <= 2047);
    return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
  endfunction

  function automatic logic [31:0] encode(bit f, logic [6:0] op, logic [2:0] f3,
                                         logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                         logic [31:0] v);
    logic [31:0] w;
    if (!f)
      w = ((v & 32'hFFF) << 20) + (32'(s1) << 15) + (32'(f3) << 12) + (32'(d) << 7) + 32'(op);
    else
      w = (((v >> 12) & 32'h1) << 31) + (((v >> 5) & 32'h3F) << 25) + (32'(s2) << 20)
        + (32'(s1) << 15) + (32'(f3) << 12) + (((v >> 1) & 32'hF) << 8)
        + (((v >> 11) & 32'h1) << 7) + 32'(op);
    return w;
  endfunction

  // independent immediate decoder (ImmSrc 0 = I, 1 = B)
  function automatic logic [31:0] decode(bit f, logic [31:0] w);
    if (!f) return {{20{w[31]}}, w[31:20]};
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // one clock: sample at negedge+1, update model, advance to next negedge
  task automatic cycle();
    logic [64:0] e;
    #1;
    if (hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_instr", out_instr, hold_instr);
      check("hold_addr", out_addr, hold_addr);
    end
    hold = 1'b0;
    accepted = in_valid && in_ready;
    if (out_valid) ov_seen++;
    if (err) err_seen++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr", out_instr, e[31:0]);
        check("instr_b", out_instr_b, e[31:0]);
        check("addr", out_addr, 32'(idx * 4));
        check("addr_b", 32'(out_addr_b), 32'((8 + idx * 4) % 16));
        check("roundtrip_imm", decode(e[64], out_instr), e[63:32]);
        last_instr  = out_instr;
        last_addr   = out_addr;
        last_addr_b = out_addr_b;
        idx++;
      end
    end else if (out_valid) begin
      hold       = 1'b1;
      hold_instr = out_instr;
      hold_addr  = out_addr;
    end
    if (accepted) begin
      if (legal(fmt, imm)) exp_q.push_back({fmt, imm, encode(fmt, opcode, funct3, rd, rs1, rs2, imm)});
      else ill_cnt++;
      check("inflight_over_2", 32'(exp_q.size() > 2), 32'd0);
    end
    if (addr_clr) idx = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: present one tuple and hold it until accepted
  task automatic send(bit f, logic [6:0] op, logic [2:0] f3, logic [4:0] d,
                      logic [4:0] s1, logic [4:0] s2, logic [31:0] v);
    fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = v;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (accepted) break;
    end
    check("send_accepted", 32'(accepted), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      cycle();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_tuple(bit legal_only);
    fmt = 1'($urandom_range(0, 1));
    opcode = 7'($urandom); funct3 = 3'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case (legal_only ? 0 : $urandom_range(0, 3))
      0: imm = fmt ? (32'($urandom_range(0, 4095)) - 32'd2048) * 2
                   : 32'($urandom_range(0, 4095)) - 32'd2048;
      1: imm = (32'($urandom_range(0, 4095)) - 32'd2048) * 2;
      2: imm = $urandom;
      default: imm = bnd[$urandom_range(0, 10)];
    endcase
  endtask

  initial begin
    int n_acc;
    int base_idx;
    bit need_new;
    in_valid = 0; fmt = 0; opcode = 0; funct3 = 0; rd = 0; rs1 = 0; rs2 = 0;
    imm = 0; addr_clr = 0; out_ready = 1;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_addr_b", 32'(out_addr_b), 32'd8);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed I-type and B-type words; B instance wraps 8, 12, 0
    send(0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    check("i_word0", last_instr, 32'h00500093);
    check("i_addr0", last_addr, 32'h0);
    check("wrap_addr0", 32'(last_addr_b), 32'd8);
    send(0, 7'h13, 3'd0, 5'd2, 5'd2, 5'd0, 32'hFFFF_FFFF);
    drain();
    check("i_word1", last_instr, 32'hFFF10113);
    check("i_addr1", last_addr, 32'h4);
    check("wrap_addr1", 32'(last_addr_b), 32'd12);
    send(1, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    drain();
    check("b_word0", last_instr, 32'h00208463);
    check("b_dec0", decode(1'b1, last_instr), 32'd8);
    check("wrap_addr2", 32'(last_addr_b), 32'd0);
    send(1, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    drain();
    check("b_word1", last_instr, 32'hFE000EE3);
    check("b_dec1", decode(1'b1, last_instr), 32'hFFFF_FFFC);
    check("b_addr1", last_addr, 32'hC);

    // illegal immediates: dropped, err held 3 cycles, address not consumed
    err_seen = 0; ov_seen = 0;
    send(0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd2048);
    send(1, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    send(1, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    repeat (3) cycle();
    check("ill_err_cycles", 32'(err_seen), 32'd3);
    check("ill_no_out", 32'(ov_seen), 32'd0);
    check("ill_err_cnt", 32'(err_cnt), 32'd3);
    send(0, 7'h13, 3'd0, 5'd3, 5'd3, 5'd0, 32'd0);
    drain();
    check("ill_next_addr", last_addr, 32'h10);

    // addr_clr coincident with the S1->S2 transfer
    send(0, 7'h13, 3'd1, 5'd4, 5'd4, 5'd0, 32'd100);
    addr_clr = 1'b1;
    cycle();
    addr_clr = 1'b0;
    send(1, 7'h63, 3'd1, 5'd0, 5'd5, 5'd6, 32'd16);
    drain();
    check("clr_next_addr", last_addr, 32'h4);
    check("clr_next_addr_b", 32'(last_addr_b), 32'd12);

    // backpressure: only two tuples fit behind a stalled output
    base_idx = int'(idx);
    out_ready = 1'b0;
    n_acc = 0;
    rand_tuple(1'b1);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (accepted) begin n_acc++; rand_tuple(1'b1); end
    end
    #1;
    check("bp_accepts", 32'(n_acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n_acc < 4; c++) begin
      cycle();
      if (accepted) begin n_acc++; if (n_acc < 4) rand_tuple(1'b1); end
    end
    in_valid = 1'b0;
    drain();
    check("bp_word_count", 32'(int'(idx) - base_idx), 32'd4);

    // randomized traffic with random backpressure
    need_new = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (need_new) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_tuple(1'b0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      need_new = accepted || !in_valid;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (2) cycle();
    check("rand_err_cnt", 32'(err_cnt), 32'(ill_cnt > 255 ? 255 : ill_cnt));

    // async reset with S1 and S2 full
    out_ready = 1'b0;
    send(0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd7);
    send(0, 7'h13, 3'd0, 5'd2, 5'd2, 5'd0, 32'd9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_instr", out_instr, 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    idx = 0; ill_cnt = 0; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(0, 7'h13, 3'd0, 5'd5, 5'd5, 5'd0, 32'd11);
    drain();
    check("post_rst_addr", last_addr, 32'h0);
    check("post_rst_addr_b", 32'(last_addr_b), 32'd8);

    // back-to-back illegal tuples: err held, counter saturates
    err_seen = 0;
    fmt = 0; imm = 32'd4096;
    in_valid = 1'b1;
    for (int c = 0; c < 260; c++) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    check("sat_err_cycles", 32'(err_seen), 32'(ill_cnt));
    check("sat_err_cnt", 32'(err_cnt), 32'(ill_cnt > 255 ? 255 : ill_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
